// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Assembles a byte stream (most-significant byte first) into 32-bit words
// and writes them to consecutive word addresses of an instruction memory,
// starting at BASE_ADDR. The processor is held halted until a HLT word
// (bits [31:26] all ones) has been written. If memory fills up before a HLT
// word arrives, the loader latches an overflow error that only reset clears.
//
// Ports
//   i_clk1          sole clock, rising edge
//   i_rst           synchronous active-high reset
//   i_start         one-cycle pulse that begins a program load
//   i_in_data       program byte stream
//   i_in_valid      i_in_data holds a valid byte
//   o_in_ready      loader accepts a byte this cycle
//   o_mem_we        one-cycle word write strobe
//   o_mem_addr      word address of the write
//   o_mem_wdata     assembled word
//   o_cpu_hold      processor held halted while high
//   o_done          load finished with HLT word written
//   o_word_count    words written in the current load
//   o_overflow_err  memory filled with no HLT word present
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk1,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LP_TOP  = '1;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_buf;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_word_count;

    logic                w_accept;
    logic                w_hlt;
    logic                w_top;
    logic                w_start_ok;

    // Address never wraps: at the top word it holds, and the FSM leaves
    // for DONE or ERR on that same write.
    function automatic logic [ADDR_W-1:0] f_addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LP_TOP) ? a : a + ADDR_W'(1);
    endfunction

    assign w_accept   = (r_state == S_LOAD) && i_in_valid;
    assign w_hlt      = (r_buf[31:26] == 6'b111111);
    assign w_top      = (r_addr == LP_TOP);
    assign w_start_ok = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

    // Next state and outputs
    always_comb begin
        w_next         = r_state;
        o_in_ready     = 1'b0;
        o_mem_we       = 1'b0;
        o_cpu_hold     = 1'b1;
        o_done         = 1'b0;
        o_overflow_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_mem_we = 1'b1;
                // HLT at the top address still counts as a clean finish.
                if (w_hlt)      w_next = S_DONE;
                else if (w_top) w_next = S_ERR;
                else            w_next = S_LOAD;
            end
            S_DONE: begin
                o_cpu_hold = 1'b0;
                o_done     = 1'b1;
                if (i_start) w_next = S_LOAD;
            end
            S_ERR: begin
                o_overflow_err = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk1) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Datapath and counters
    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_byte_idx   <= 2'd0;
            r_addr       <= LP_BASE;
            r_word_count <= '0;
        end else if (w_start_ok) begin
            r_byte_idx   <= 2'd0;
            r_addr       <= LP_BASE;
            r_word_count <= '0;
            r_buf        <= '0;
        end else if (w_accept) begin
            r_buf      <= {r_buf[23:0], i_in_data};
            r_byte_idx <= r_byte_idx + 2'd1;
        end else if (r_state == S_WRITE) begin
            r_word_count <= r_word_count + (ADDR_W+1)'(1);
            r_addr       <= f_addr_inc(r_addr);
            r_byte_idx   <= 2'd0;
        end
    end

    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_buf;
    assign o_word_count = r_word_count;

endmodule
